// File: rtl/rrom_pkg.sv
// rrom_pkg: definitions shared by the remote-ROM response deframer and the
// command-side framer.
//
// Contents:
//    SYNC               value carried in header bits [7:4] of every frame
//    ERR_BIT            header bit that carries the remote error flag
//    SIZE_MSB/SIZE_LSB  header field holding log2 of the data byte count
//    state_e            deframer FSM states
//    N(size)            number of data bytes in a frame of the given size
package rrom_pkg;

   localparam logic [3:0] SYNC     = 4'h5;
   localparam int         ERR_BIT  = 3;
   localparam int         SIZE_MSB = 1;
   localparam int         SIZE_LSB = 0;

   typedef enum logic [1:0] {
      HDR  = 2'd0,
      DATA = 2'd1,
      CSUM = 2'd2,
      OUT  = 2'd3
   } state_e;

   function automatic logic [3:0] N(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/rrom_rsp_deframer_if.sv
// rrom_rsp_deframer_if: bundles the response FIFO read port, the assembled
// response port and the status outputs of the deframer.
//
// Signals:
//    empty, dout    FIFO empty flag and data (data valid the cycle after rd_en)
//    rd_en          FIFO pop
//    rsp_valid/rsp_ready/rsp_data/rsp_size/rsp_error  response handshake
//    busy, resync_cnt  status
//
// Modports: master = deframer side, slave = FIFO/consumer side.
interface rrom_rsp_deframer_if;

   logic        empty;
   logic        rd_en;
   logic [7:0]  dout;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic [1:0]  rsp_size;
   logic        rsp_error;
   logic        busy;
   logic [7:0]  resync_cnt;

   modport master (
      input  empty, dout, rsp_ready,
      output rd_en, rsp_valid, rsp_data, rsp_size, rsp_error, busy, resync_cnt
   );

   modport slave (
      output empty, dout, rsp_ready,
      input  rd_en, rsp_valid, rsp_data, rsp_size, rsp_error, busy, resync_cnt
   );

endinterface

// File: rtl/rrom_rsp_deframer.sv
// rrom_rsp_deframer: pops framed response bytes from a standard (non-FWFT)
// FIFO, checks the sync nibble and XOR checksum, and reassembles 1/2/4/8 data
// bytes (LSB first) into one 64-bit word presented on a valid/ready port.
// An inter-byte timeout aborts a stalled frame so the bus never hangs.
//
// Ports:
//    clk    system clock
//    rst_n  asynchronous active-low reset
//    bus    rrom_rsp_deframer_if.master (FIFO read side, response port, status)
//
// Parameters:
//    TIMEOUT_CYC  cycles allowed between bytes inside a frame
//    SYNC         required header nibble
module rrom_rsp_deframer #(
   parameter int         TIMEOUT_CYC = 1024,
   parameter logic [3:0] SYNC        = rrom_pkg::SYNC
) (
   input logic                 clk,
   input logic                 rst_n,
   rrom_rsp_deframer_if.master bus
);
   import rrom_pkg::*;

   localparam logic [1:0] S_HDR  = HDR;
   localparam logic [1:0] S_DATA = DATA;
   localparam logic [1:0] S_CSUM = CSUM;
   localparam logic [1:0] S_OUT  = OUT;

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [1:0]    state_q, state_d;
   logic          pend_q, pend_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    csum_q, csum_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
   logic [1:0]    size_q, size_d;
   logic [63:0]   data_q, data_d;
   logic          valid_q, valid_d;
   logic          rsp_err_q, rsp_err_d;
   logic [7:0]    resync_q, resync_d;

   logic          pop_w;
   logic          land_w;
   logic          in_frame_w;
   logic          tmo_hit_w;

   always_comb begin
      // Only one byte may be in flight: the byte popped last cycle lands now.
      pop_w      = !bus.empty && !pend_q && (state_q != S_OUT);
      land_w     = pend_q;
      in_frame_w = (state_q == S_DATA) || (state_q == S_CSUM);
      // A byte landing in the expiry cycle takes priority over the timeout.
      tmo_hit_w  = in_frame_w && !land_w && (tmo_q == TW'(TIMEOUT_CYC - 1));

      state_d   = state_q;
      pend_d    = pop_w;
      idx_d     = idx_q;
      csum_d    = csum_q;
      err_d     = err_q;
      size_d    = size_q;
      data_d    = data_q;
      valid_d   = valid_q;
      rsp_err_d = rsp_err_q;
      resync_d  = resync_q;
      tmo_d     = (in_frame_w && !land_w) ? tmo_q + TW'(1) : '0;

      case (state_q)
         S_HDR: begin
            if (land_w) begin
               if (bus.dout[7:4] != SYNC) begin
                  resync_d = (resync_q == 8'hFF) ? resync_q : resync_q + 8'd1;
               end else begin
                  size_d  = bus.dout[SIZE_MSB:SIZE_LSB];
                  err_d   = bus.dout[ERR_BIT];
                  csum_d  = bus.dout;
                  idx_d   = 3'd0;
                  data_d  = '0;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (land_w) begin
               data_d[8*idx_q +: 8] = bus.dout;
               csum_d               = csum_q ^ bus.dout;
               if ({1'b0, idx_q} == N(size_q) - 4'd1) begin
                  state_d = S_CSUM;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else if (tmo_hit_w) begin
               state_d   = S_OUT;
               valid_d   = 1'b1;
               rsp_err_d = 1'b1;
            end
         end
         S_CSUM: begin
            if (land_w) begin
               rsp_err_d = err_q | (bus.dout != csum_q);
               valid_d   = 1'b1;
               state_d   = S_OUT;
            end else if (tmo_hit_w) begin
               state_d   = S_OUT;
               valid_d   = 1'b1;
               rsp_err_d = 1'b1;
            end
         end
         default: begin
            // A byte popped just before a timeout lands here and is dropped.
            if (valid_q && bus.rsp_ready) begin
               valid_d = 1'b0;
               state_d = S_HDR;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_HDR;
         pend_q    <= 1'b0;
         idx_q     <= 3'd0;
         csum_q    <= 8'd0;
         tmo_q     <= '0;
         err_q     <= 1'b0;
         size_q    <= 2'd0;
         data_q    <= 64'd0;
         valid_q   <= 1'b0;
         rsp_err_q <= 1'b0;
         resync_q  <= 8'd0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         idx_q     <= idx_d;
         csum_q    <= csum_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         size_q    <= size_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         rsp_err_q <= rsp_err_d;
         resync_q  <= resync_d;
      end
   end

   // rd_en is combinational; gating with rst_n keeps it low while in reset.
   assign bus.rd_en      = rst_n && pop_w;
   assign bus.rsp_valid  = valid_q;
   assign bus.rsp_data   = data_q;
   assign bus.rsp_size   = size_q;
   assign bus.rsp_error  = rsp_err_q;
   assign bus.busy       = (state_q != S_HDR);
   assign bus.resync_cnt = resync_q;

endmodule

// File: tb/tb_rrom_rsp_deframer.sv
// tb_rrom_rsp_deframer: drives rrom_rsp_deframer from a queue-based FIFO model
// and compares every response against a frame-level reference model.
module tb_rrom_rsp_deframer;

   localparam int         TMO      = 1024;
   localparam logic [3:0] SYNC_NIB = 4'h5;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [63:0] data;
      logic [1:0]  size;
      logic        err;
      int          resync;
   } rsp_t;
   typedef rsp_t rq_t[$];

   logic        clk;
   logic        rst_n;
   logic        empty_r = 1'b1;
   logic [7:0]  dout_r  = 8'd0;
   logic        rd_s    = 1'b0;
   bq_t         fifo_q;
   int          cyc = 0, pops = 0, last_pop = 0;
   int          n_checks = 0, n_fail = 0;
   int          exp_resync = 0;
   int          valid_cyc = 0, pop_at_valid = 0, last_pops = 0;
   logic [63:0] last_data;
   logic [1:0]  last_size;
   logic        last_err;

   rrom_rsp_deframer_if bus();

   assign bus.empty = empty_r;
   assign bus.dout  = dout_r;

   rrom_rsp_deframer #(.TIMEOUT_CYC(TMO), .SYNC(SYNC_NIB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // rd_en is sampled just before each rising edge to avoid racing the DUT.
   always @(negedge clk) begin
      #4;
      rd_s = bus.rd_en;
   end

   always @(posedge clk) begin
      cyc++;
      if (rd_s && fifo_q.size() > 0) begin
         dout_r <= fifo_q.pop_front();
         pops++;
         last_pop = cyc;
      end
      empty_r <= (fifo_q.size() == 0);
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Frame-level reference: scans the byte stream, skipping non-sync bytes;
   // a frame cut short by the end of the stream is reported as a timeout.
   function automatic void model(input bq_t s, input int base, output rq_t out, output int fin);
      int          i, nb, got, rs;
      logic [7:0]  h, x;
      rsp_t        r;
      out = {};
      i   = 0;
      rs  = base;
      while (i < s.size()) begin
         h = s[i];
         if (h[7:4] != SYNC_NIB) begin
            if (rs < 255) rs++;
            i++;
         end else begin
            nb       = 1 << h[1:0];
            x        = h;
            got      = 0;
            r.data   = '0;
            r.size   = h[1:0];
            r.resync = rs;
            for (int k = 0; k < nb; k++) begin
               if (i + 1 + k < s.size()) begin
                  r.data[8*k +: 8] = s[i+1+k];
                  x = x ^ s[i+1+k];
                  got++;
               end
            end
            if (got == nb && i + 1 + nb < s.size()) begin
               r.err = h[3] | (s[i+1+nb] != x);
               i     = i + nb + 2;
            end else begin
               r.err = 1'b1;
               i     = s.size();
            end
            out.push_back(r);
         end
      end
      fin = rs;
   endfunction

   function automatic bq_t make_frame(input logic [7:0] hdr, input bq_t d, input logic [7:0] flip);
      bq_t        f;
      logic [7:0] x;
      f = {};
      f.push_back(hdr);
      x = hdr;
      foreach (d[i]) begin
         f.push_back(d[i]);
         x = x ^ d[i];
      end
      f.push_back(x ^ flip);
      return f;
   endfunction

   task automatic applyStimulus(input bq_t s);
      foreach (s[i]) fifo_q.push_back(s[i]);
   endtask

   task automatic checkOutput(input rsp_t e, input int stall, input string tag);
      int          n, p0;
      logic [63:0] d0;
      logic        ok;
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (bus.rsp_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL %s rsp_valid: got %b, want 1 within %0d cycles", tag, bus.rsp_valid, n);
         return;
      end
      valid_cyc    = cyc;
      pop_at_valid = last_pop;
      last_pops    = pops;
      last_data    = bus.rsp_data;
      last_size    = bus.rsp_size;
      last_err     = bus.rsp_error;
      n_checks++;
      if (bus.rsp_data !== e.data) begin
         n_fail++;
         $display("[TB] FAIL %s rsp_data: got %h, want %h", tag, bus.rsp_data, e.data);
      end
      n_checks++;
      if (bus.rsp_size !== e.size) begin
         n_fail++;
         $display("[TB] FAIL %s rsp_size: got %0d, want %0d", tag, bus.rsp_size, e.size);
      end
      n_checks++;
      if (bus.rsp_error !== e.err) begin
         n_fail++;
         $display("[TB] FAIL %s rsp_error: got %b, want %b", tag, bus.rsp_error, e.err);
      end
      n_checks++;
      if (bus.resync_cnt !== 8'(e.resync)) begin
         n_fail++;
         $display("[TB] FAIL %s resync_cnt: got %0d, want %0d", tag, bus.resync_cnt, e.resync);
      end
      p0 = pops;
      d0 = bus.rsp_data;
      ok = 1'b1;
      repeat (stall) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 || pops != p0) ok = 1'b0;
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL %s hold: valid=%b data=%h pops=%0d, want 1/%h/%0d", tag,
                  bus.rsp_valid, bus.rsp_data, pops, d0, p0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL %s release: rsp_valid got %b, want 0", tag, bus.rsp_valid);
      end
   endtask

   task automatic collect_stream(input bq_t s, input int first_stall, input int stall_max, input string tag);
      rq_t e;
      int  fin, n, st;
      model(s, exp_resync, e, fin);
      foreach (e[i]) begin
         st = (i == 0 && first_stall >= 0) ? first_stall : int'($urandom_range(0, stall_max));
         checkOutput(e[i], st, tag);
      end
      n = 0;
      while ((fifo_q.size() != 0 || empty_r !== 1'b1 || bus.busy !== 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.resync_cnt !== 8'(fin)) begin
         n_fail++;
         $display("[TB] FAIL %s final resync_cnt: got %0d, want %0d", tag, bus.resync_cnt, fin);
      end
      exp_resync = fin;
   endtask

   task automatic run_stream(input bq_t s, input int first_stall, input int stall_max, input string tag);
      applyStimulus(s);
      collect_stream(s, first_stall, stall_max, tag);
   endtask

   task automatic test_reset();
      bq_t g;
      bus.rsp_ready = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.rd_en, bus.rsp_valid, bus.rsp_error, bus.busy} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL reset flags: rd_en/valid/error/busy got %b, want 0000",
                  {bus.rd_en, bus.rsp_valid, bus.rsp_error, bus.busy});
      end
      n_checks++;
      if (bus.rsp_data !== 64'd0 || bus.rsp_size !== 2'd0 || bus.resync_cnt !== 8'd0) begin
         n_fail++;
         $display("[TB] FAIL reset values: data=%h size=%0d resync=%0d, want 0/0/0",
                  bus.rsp_data, bus.rsp_size, bus.resync_cnt);
      end
      @(negedge clk);
      g = {8'h00};
      applyStimulus(g);
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (bus.rd_en !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset rd_en with data: got %b, want 0", bus.rd_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_resync = 0;
      collect_stream(g, -1, 0, "reset_garbage");
   endtask

   task automatic test_full_word();
      bq_t d, s;
      int  p0;
      d  = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
      s  = make_frame(8'h53, d, 8'h00);
      p0 = pops;
      run_stream(s, 2, 0, "full_word");
      n_checks++;
      if (last_data !== 64'hEFCD_AB89_6745_2301 || last_size !== 2'd3 || last_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL full_word const: got %h/%0d/%b, want efcdab8967452301/3/0",
                  last_data, last_size, last_err);
      end
      n_checks++;
      if (last_pops - p0 != 10) begin
         n_fail++;
         $display("[TB] FAIL full_word pops: got %0d, want 10", last_pops - p0);
      end
   endtask

   task automatic test_stall_no_pop();
      bq_t s, d;
      logic [31:0] r;
      s = {8'h50, 8'hA5, 8'hF5};
      d = {};
      for (int i = 0; i < 4; i++) begin
         r = $urandom;
         d.push_back(r[7:0]);
      end
      s = {s, make_frame(8'h52, d, 8'h00)};
      run_stream(s, 20, 0, "stall");
      n_checks++;
      if (last_data !== {32'd0, d[3], d[2], d[1], d[0]} || last_size !== 2'd2) begin
         n_fail++;
         $display("[TB] FAIL stall second: got %h/%0d, want %h/2", last_data, last_size,
                  {32'd0, d[3], d[2], d[1], d[0]});
      end
   endtask

   task automatic test_resync();
      bq_t s, d;
      int  r0;
      d  = {8'h3C, 8'hC3};
      s  = {8'h00, 8'hFF, 8'h12};
      s  = {s, make_frame(8'h51, d, 8'h00)};
      r0 = exp_resync;
      run_stream(s, 1, 0, "resync");
      n_checks++;
      if (bus.resync_cnt !== 8'(r0 + 3) || last_data !== 64'h0000_0000_0000_C33C) begin
         n_fail++;
         $display("[TB] FAIL resync count/data: got %0d/%h, want %0d/000000000000c33c",
                  bus.resync_cnt, last_data, r0 + 3);
      end
   endtask

   task automatic test_checksum_err();
      bq_t d, s;
      d = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      s = make_frame(8'h53, d, 8'hFF);
      run_stream(s, 0, 0, "csum_bad");
      n_checks++;
      if (last_err !== 1'b1 || last_data !== 64'h8877_6655_4433_2211) begin
         n_fail++;
         $display("[TB] FAIL csum_bad: got err=%b data=%h, want 1/8877665544332211", last_err, last_data);
      end
      s = make_frame(8'h5B, d, 8'h00);
      run_stream(s, 0, 0, "remote_err");
      n_checks++;
      if (last_err !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL remote_err: got err=%b, want 1", last_err);
      end
   endtask

   task automatic test_timeout();
      bq_t s;
      s = {8'h53, 8'h9A, 8'hBC, 8'hDE};
      run_stream(s, 0, 0, "timeout");
      n_checks++;
      if (valid_cyc - pop_at_valid - 1 != TMO) begin
         n_fail++;
         $display("[TB] FAIL timeout latency: got %0d, want %0d", valid_cyc - pop_at_valid - 1, TMO);
      end
      n_checks++;
      if (last_err !== 1'b1 || last_data !== 64'h0000_0000_00DE_BC9A) begin
         n_fail++;
         $display("[TB] FAIL timeout data: got err=%b data=%h, want 1/0000000000debc9a", last_err, last_data);
      end
   endtask

   task automatic test_reset_midframe();
      bq_t d, s, left;
      logic [31:0] r;
      int  p0, n;
      d = {};
      for (int i = 0; i < 8; i++) begin
         r = $urandom;
         d.push_back(r[7:0]);
      end
      s = make_frame(8'h53, d, 8'h00);
      applyStimulus(s);
      p0 = pops;
      n  = 0;
      while (pops - p0 < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.rsp_data[31:0] !== {d[3], d[2], d[1], d[0]}) begin
         n_fail++;
         $display("[TB] FAIL midframe partial: busy=%b data=%h, want 1/%h", bus.busy,
                  bus.rsp_data[31:0], {d[3], d[2], d[1], d[0]});
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.rd_en, bus.rsp_valid, bus.rsp_error, bus.busy} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL midframe reset flags: got %b, want 0000",
                  {bus.rd_en, bus.rsp_valid, bus.rsp_error, bus.busy});
      end
      n_checks++;
      if (bus.rsp_data !== 64'd0 || bus.rsp_size !== 2'd0 || bus.resync_cnt !== 8'd0) begin
         n_fail++;
         $display("[TB] FAIL midframe reset values: data=%h size=%0d resync=%0d, want 0/0/0",
                  bus.rsp_data, bus.rsp_size, bus.resync_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_resync = 0;
      left = fifo_q;
      collect_stream(left, -1, 1, "midframe_left");
   endtask

   task automatic test_random();
      bq_t s, d;
      logic [31:0] r;
      logic [7:0]  g, h;
      s = {};
      for (int f = 0; f < 30; f++) begin
         r = $urandom_range(0, 2);
         for (int k = 0; k < int'(r); k++) begin
            g = 8'($urandom_range(0, 255));
            if (g[7:4] == SYNC_NIB) g[7:4] = 4'hA;
            s.push_back(g);
         end
         r = $urandom;
         h = {SYNC_NIB, (r[4:2] == 3'd0), r[5], r[1:0]};
         d = {};
         for (int k = 0; k < (1 << h[1:0]); k++) d.push_back(8'($urandom_range(0, 255)));
         r = $urandom;
         s = {s, make_frame(h, d, (r[3:0] == 4'd0) ? 8'($urandom_range(1, 255)) : 8'h00)};
      end
      run_stream(s, -1, 3, "random");
   endtask

   initial begin
      bus.rsp_ready = 1'b0;
      rst_n = 1'b1;
      test_reset();
      test_full_word();
      test_stall_no_pop();
      test_resync();
      test_checksum_err();
      test_timeout();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
